sieve_mem_arb: RTL and testbench

- Two-requester arbiter and sequencer for the sieve's single-port 256x8 synchronous-read RAM.
- Port 0 is the sieve engine (marks composites). Port 1 is the host readout/clear path.
- Arbitrates per cycle with round-robin fairness and optional bounded lock bursts.
- Registers the RAM command and returns read data tagged to the requester that issued it.

---
 rtl/sieve_mem_arb.sv | 163 ++++++++++++++++
 tb/tb_sieve_mem_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sieve_mem_arb.sv
// Two-port arbiter and sequencer for the sieve's single-port synchronous-read RAM.
// Port 0 is the sieve engine, port 1 the host readout/clear path. One transfer per
// cycle, round-robin on ties, optional bounded lock bursts, read data returned
// three edges after accept and tagged to the issuing port.
module sieve_mem_arb #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dout,
    input  logic [DW-1:0] mem_din,
    output logic          busy
);

    localparam logic [3:0] BurstMax = 4'(MAX_BURST);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;

    // Read-tag pipeline: stage 1 tracks the RAM address cycle, stage 2 the data cycle.
    logic       s1_valid_q, s1_port_q;
    logic       s2_valid_q, s2_port_q;

    logic          acc0, acc1, acc_any;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Grant decode: owner keeps the port until its burst budget runs out under contention.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    // last_q names the previous winner; the other port wins the tie
                    if (last_q) gnt0 = 1'b1;
                    else        gnt1 = 1'b1;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
            StOwn0: begin
                if (req0 && (cnt_q < BurstMax || !req1)) gnt0 = 1'b1;
                else if (req1)                           gnt1 = 1'b1;
            end
            StOwn1: begin
                if (req1 && (cnt_q < BurstMax || !req0)) gnt1 = 1'b1;
                else if (req0)                           gnt0 = 1'b1;
            end
            default: ;
        endcase
    end

    assign acc0    = req0 & gnt0;
    assign acc1    = req1 & gnt1;
    assign acc_any = acc0 | acc1;
    assign cnt_inc = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;

    // Winner's command fields; only meaningful when acc_any is high.
    assign sel_we    = acc1 ? we1    : we0;
    assign sel_addr  = acc1 ? addr1  : addr0;
    assign sel_wdata = acc1 ? wdata1 : wdata0;

    // Ownership next state: any cycle without an accept drops back to idle.
    always_comb begin
        state_d = StIdle;
        cnt_d   = 4'd0;
        last_d  = last_q;
        if (acc0) begin
            last_d = 1'b0;
            if (lock0) begin
                state_d = StOwn0;
                cnt_d   = (state_q == StOwn0) ? cnt_inc : 4'd1;
            end
        end else if (acc1) begin
            last_d = 1'b1;
            if (lock1) begin
                state_d = StOwn1;
                cnt_d   = (state_q == StOwn1) ? cnt_inc : 4'd1;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command stage: register the accepted transfer towards the RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_dout   <= '0;
            s1_valid_q <= 1'b0;
            s1_port_q  <= 1'b0;
        end else begin
            mem_wr     <= acc_any & sel_we;
            s1_valid_q <= acc_any & ~sel_we;
            s1_port_q  <= acc1;
            if (acc_any) begin
                mem_addr <= sel_addr;
                mem_dout <= sel_wdata;
            end
        end
    end

    // Tag follows the RAM's read latency; returned data lands on the issuing port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_port_q  <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_port_q  <= s1_port_q;
            rvalid0    <= s2_valid_q & ~s2_port_q;
            rvalid1    <= s2_valid_q & s2_port_q;
            if (s2_valid_q && !s2_port_q) rdata0 <= mem_din;
            if (s2_valid_q && s2_port_q)  rdata1 <= mem_din;
        end
    end

    assign busy = s1_valid_q | s2_valid_q | (state_q != StIdle);

endmodule

// File: tb/tb_sieve_mem_arb.sv
// Directed bench for sieve_mem_arb with a write-first synchronous-read RAM model.
module tb_sieve_mem_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_wr, busy;
    logic [7:0] rdata0, rdata1, mem_addr, mem_dout;
    logic [7:0] mem_din = 8'h00;
    logic [7:0] ram [256] = '{default: 8'h00};

    int checks = 0;
    int errors = 0;

    sieve_mem_arb #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Write-first single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_addr] <= mem_dout;
            mem_din       <= mem_dout;
        end else begin
            mem_din <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
        tick(); tick();
        chk("rst_mem_wr",   32'(mem_wr),   'h0);
        chk("rst_mem_addr", 32'(mem_addr), 'h0);
        chk("rst_mem_dout", 32'(mem_dout), 'h0);
        chk("rst_rvalid0",  32'(rvalid0),  'h0);
        chk("rst_rvalid1",  32'(rvalid1),  'h0);
        chk("rst_busy",     32'(busy),     'h0);

        // Release; both ports write, port 0 wins first, then alternation.
        rst = 1'b1;
        req0 = 1; we0 = 1; addr0 = 8'h05; wdata0 = 8'h3C;
        req1 = 1; we1 = 1; addr1 = 8'h11; wdata1 = 8'h01;
        #1;
        chk("alt_gnt0_a", 32'(gnt0), 'h1);
        chk("alt_gnt1_a", 32'(gnt1), 'h0);
        tick();
        chk("alt_mem_wr",   32'(mem_wr),   'h1);
        chk("alt_mem_addr", 32'(mem_addr), 'h05);
        chk("alt_mem_dout", 32'(mem_dout), 'h3C);
        chk("alt_gnt0_b", 32'(gnt0), 'h0);
        chk("alt_gnt1_b", 32'(gnt1), 'h1);
        tick();
        chk("alt_mem_addr2", 32'(mem_addr), 'h11);
        chk("alt_gnt0_c", 32'(gnt0), 'h1);
        req0 = 0; req1 = 0;
        #1;
        chk("nogrant_gnt0", 32'(gnt0), 'h0);
        tick();
        chk("idle_mem_wr",   32'(mem_wr),   'h0);
        chk("idle_addr_hold", 32'(mem_addr), 'h11);
        chk("idle_busy",     32'(busy),     'h0);

        // Single read on port 1 of 0x05.
        req1 = 1; we1 = 0; addr1 = 8'h05;
        #1;
        chk("rd1_gnt1", 32'(gnt1), 'h1);
        tick();
        req1 = 0;
        chk("rd1_mem_addr", 32'(mem_addr), 'h05);
        chk("rd1_mem_wr",   32'(mem_wr),   'h0);
        chk("rd1_busy",     32'(busy),     'h1);
        tick();
        chk("rd1_rvalid1_early", 32'(rvalid1), 'h0);
        tick();
        chk("rd1_rvalid1", 32'(rvalid1), 'h1);
        chk("rd1_rdata1",  32'(rdata1),  'h3C);
        chk("rd1_rvalid0", 32'(rvalid0), 'h0);
        tick();
        chk("rd1_rvalid1_off", 32'(rvalid1), 'h0);
        chk("rd1_rdata1_hold", 32'(rdata1),  'h3C);

        // Lock burst under contention: four port-0 accepts, then port 1.
        req0 = 1; we0 = 1; lock0 = 1; wdata0 = 8'hD4;
        req1 = 1; we1 = 1; lock1 = 0; addr1 = 8'h90; wdata1 = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            addr0 = 8'(8'h04 + 2 * i);
            #1;
            chk("burst_gnt0", 32'(gnt0), 'h1);
            chk("burst_gnt1", 32'(gnt1), 'h0);
            tick();
            chk("burst_addr", 32'(mem_addr), 32'(8'h04 + 2 * i));
        end
        chk("burst_handoff_gnt1", 32'(gnt1), 'h1);
        chk("burst_handoff_gnt0", 32'(gnt0), 'h0);
        tick();
        chk("burst_p1_addr", 32'(mem_addr), 'h90);
        addr0 = 8'h0C;
        #1;
        chk("burst_resume_gnt0", 32'(gnt0), 'h1);
        tick();
        chk("burst_resume_addr", 32'(mem_addr), 'h0C);

        // Lock with no contention: port 0 streams until the counter saturates.
        req1 = 0;
        for (int i = 0; i < 16; i++) begin
            addr0 = 8'(8'h20 + i);
            #1;
            chk("solo_gnt0", 32'(gnt0), 'h1);
            tick();
            chk("solo_addr", 32'(mem_addr), 32'(8'h20 + i));
        end
        chk("solo_busy", 32'(busy), 'h1);
        req1 = 1;
        #1;
        chk("solo_contend_gnt1", 32'(gnt1), 'h1);
        chk("solo_contend_gnt0", 32'(gnt0), 'h0);
        req1 = 0; req0 = 0; lock0 = 0;
        tick();
        chk("solo_drop_busy",   32'(busy),   'h0);
        chk("solo_drop_mem_wr", 32'(mem_wr), 'h0);

        // Interleaved reads: port 0 @0x10 then port 1 @0x11.
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        req0 = 0;
        req1 = 1; we1 = 0; addr1 = 8'h11;
        chk("il_addr0", 32'(mem_addr), 'h10);
        tick();
        req1 = 0;
        chk("il_addr1", 32'(mem_addr), 'h11);
        tick();
        chk("il_rvalid0", 32'(rvalid0), 'h1);
        chk("il_rdata0",  32'(rdata0),  'h00);
        chk("il_rvalid1_a", 32'(rvalid1), 'h0);
        tick();
        chk("il_rvalid1", 32'(rvalid1), 'h1);
        chk("il_rdata1",  32'(rdata1),  'h01);
        chk("il_rvalid0_b", 32'(rvalid0), 'h0);

        // Read-after-write on consecutive port-0 accepts.
        req0 = 1; we0 = 1; addr0 = 8'h33; wdata0 = 8'h77;
        #1;
        chk("raw_gnt0", 32'(gnt0), 'h1);
        tick();
        we0 = 0;
        tick();
        req0 = 0;
        tick();
        tick();
        chk("raw_rvalid0", 32'(rvalid0), 'h1);
        chk("raw_rdata0",  32'(rdata0),  'h77);

        // Asynchronous reset one cycle after a read accept.
        tick();
        req0 = 1; we0 = 0; addr0 = 8'h05;
        tick();
        req0 = 0;
        chk("rstf_busy_pre", 32'(busy), 'h1);
        #3;
        rst = 1'b0;
        #1;
        chk("rstf_mem_addr", 32'(mem_addr), 'h0);
        chk("rstf_mem_dout", 32'(mem_dout), 'h0);
        chk("rstf_mem_wr",   32'(mem_wr),   'h0);
        chk("rstf_rdata0",   32'(rdata0),   'h0);
        chk("rstf_rdata1",   32'(rdata1),   'h0);
        chk("rstf_busy",     32'(busy),     'h0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstf_no_rvalid0", 32'(rvalid0), 'h0);
            chk("rstf_post_mem_wr", 32'(mem_wr), 'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
